// File: rtl/wall_painter_if.sv
// Bus bundle between the wall painter, its sprite ROM and the frame buffer.
interface wall_painter_if;
    logic [18:0] rom_addr;
    logic [3:0]  rom_data;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [3:0]  fb_data;
    logic        fb_ack;

    modport master (
        output rom_addr,
        input  rom_data,
        output fb_we,
        output fb_addr,
        output fb_data,
        input  fb_ack
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  fb_we,
        input  fb_addr,
        input  fb_data,
        output fb_ack
    );
endinterface

// File: rtl/wall_painter.sv
// Paints the left and right wall columns of every row from a column-indexed sprite ROM
// into the frame buffer, skipping transparent (index 0) pixels.
module wall_painter #(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned LEFT_W  = 10,
    parameter int unsigned RIGHT_X = 629
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           start,
    wall_painter_if.master bus,
    output logic           busy,
    output logic           done
);

    localparam logic [18:0] XLeftLast = 19'(LEFT_W - 1);
    localparam logic [18:0] XRight    = 19'(RIGHT_X);
    localparam logic [18:0] XLast     = 19'(H_RES - 1);
    localparam logic [18:0] YLast     = 19'(V_RES - 1);
    localparam logic [18:0] HRes      = 19'(H_RES);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWrite,
        StNext,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [18:0] x_q, x_d;
    logic [18:0] y_q, y_d;
    logic [18:0] row_base_q, row_base_d;
    logic [3:0]  pix_q, pix_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            pix_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            pix_q      <= pix_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        pix_d      = pix_q;
        bus.fb_we  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d        = '0;
                    y_d        = '0;
                    row_base_d = '0;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                pix_d   = bus.rom_data;
                state_d = (bus.rom_data != 4'd0) ? StWrite : StNext;
            end
            StWrite: begin
                bus.fb_we = 1'b1;
                if (bus.fb_ack) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                // End of row is tested first so the frame terminates even if walls touch.
                if (x_q == XLast) begin
                    if (y_q == YLast) begin
                        state_d = StDone;
                    end else begin
                        x_d        = '0;
                        y_d        = y_q + 19'd1;
                        row_base_d = row_base_q + HRes;
                        state_d    = StFetch;
                    end
                end else begin
                    x_d     = (x_q == XLeftLast) ? XRight : x_q + 19'd1;
                    state_d = StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.rom_addr = x_q;
    assign bus.fb_addr  = row_base_q + x_q;
    assign bus.fb_data  = pix_q;
    assign busy         = (state_q == StFetch) || (state_q == StWrite) || (state_q == StNext);
    assign done         = (state_q == StDone);

endmodule

// File: tb/tb_wall_painter.sv
// Randomized self-checking bench: an expected-write queue built from the ROM contents and
// wall geometry is checked against every frame-buffer write the painter issues.
module tb_wall_painter;
    localparam int unsigned H_RES   = 640;
    localparam int unsigned V_RES   = 480;
    localparam int unsigned LEFT_W  = 10;
    localparam int unsigned RIGHT_X = 629;

    typedef struct packed {
        logic [18:0] a;
        logic [3:0]  d;
    } wr_t;

    logic Clk = 1'b0;
    logic Reset;
    logic start;
    logic busy;
    logic done;

    wall_painter_if bus ();

    wall_painter #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .LEFT_W (LEFT_W),
        .RIGHT_X(RIGHT_X)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .start(start),
        .bus  (bus),
        .busy (busy),
        .done (done)
    );

    always #5 Clk = ~Clk;

    logic [3:0] rom_tab [H_RES];
    assign bus.rom_data = (bus.rom_addr < 19'(H_RES)) ? rom_tab[bus.rom_addr[9:0]] : 4'd0;

    // ack_mode 0: tied high, 1: random, 2: follows ack_man
    int   ack_mode = 0;
    logic ack_man  = 1'b0;
    always @(posedge Clk) begin
        #1;
        case (ack_mode)
            0:       bus.fb_ack = 1'b1;
            1:       bus.fb_ack = ($urandom_range(0, 2) == 0);
            default: bus.fb_ack = ack_man;
        endcase
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_wr;
    int          n_done;
    int          n_col3;
    logic [18:0] last_addr;
    logic [18:0] first_addr [32];
    logic [3:0]  first_data;
    bit          checking = 1'b0;
    wr_t         exp_q [$];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_wall(input int unsigned x);
        return (x < LEFT_W) || (x >= RIGHT_X && x < H_RES);
    endfunction

    task automatic build_model();
        exp_q.delete();
        for (int unsigned y = 0; y < V_RES; y++) begin
            for (int unsigned x = 0; x < H_RES; x++) begin
                if (is_wall(x) && rom_tab[x] != 4'd0) begin
                    exp_q.push_back('{a: 19'(y * H_RES + x), d: rom_tab[x]});
                end
            end
        end
    endtask

    // Number of writes that precede pixel address a in a pass.
    function automatic int count_before(input int unsigned a);
        int nz = 0;
        int part = 0;
        for (int unsigned x = 0; x < H_RES; x++) begin
            if (is_wall(x) && rom_tab[x] != 4'd0) begin
                nz++;
                if (x < a % H_RES) part++;
            end
        end
        return int'(a / H_RES) * nz + part;
    endfunction

    always @(negedge Clk) begin
        if (checking) begin
            if (bus.fb_we) begin
                check("busy_in_write", busy, 1);
                check("addr_in_range", (bus.fb_addr <= 19'(H_RES * V_RES - 1)), 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", bus.fb_addr, 0);
                    n_bad++;
                    $display("FAIL extra_write: got addr %0d expected no write", bus.fb_addr);
                end else begin
                    check("wr_addr", bus.fb_addr, exp_q[0].a);
                    check("wr_data", bus.fb_data, exp_q[0].d);
                    if (bus.fb_ack) begin
                        void'(exp_q.pop_front());
                        if (n_wr < 32) first_addr[n_wr] = bus.fb_addr;
                        if (n_wr == 0) first_data = bus.fb_data;
                        if (bus.fb_addr % 19'(H_RES) == 19'd3) n_col3++;
                        last_addr = bus.fb_addr;
                        n_wr++;
                    end
                end
            end
            if (done) begin
                n_done++;
                check("busy_at_done", busy, 0);
                check("queue_empty_at_done", exp_q.size(), 0);
            end
        end
    end

    task automatic start_pass();
        build_model();
        n_wr     = 0;
        n_done   = 0;
        n_col3   = 0;
        checking = 1'b1;
        @(posedge Clk);
        #1 start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (n_done < 1 && t < budget) begin
            @(negedge Clk);
            t++;
        end
        check("done_within_budget", n_done, 1);
        repeat (3) @(negedge Clk);
    endtask

    // Waits for a write at or beyond address tgt, then settles past the negedge sample.
    task automatic wait_write_at(input int unsigned tgt, output logic [18:0] a);
        int t = 0;
        do begin
            @(negedge Clk);
            t++;
        end while (!(bus.fb_we && bus.fb_addr >= 19'(tgt)) && t < 20000);
        check("write_reached", (bus.fb_we && bus.fb_addr >= 19'(tgt)), 1);
        a = bus.fb_addr;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fb_we"}, bus.fb_we, 0);
        check({tag, "_fb_addr"}, bus.fb_addr, 0);
        check({tag, "_fb_data"}, bus.fb_data, 0);
        check({tag, "_rom_addr"}, bus.rom_addr, 0);
    endtask

    initial begin
        logic [18:0] a;
        int          t;
        int unsigned r;

        Reset = 1'b1;
        start = 1'b0;
        foreach (rom_tab[i]) rom_tab[i] = 4'd5;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check_reset_outputs("reset");

        // Solid walls, immediate ack: full frame.
        start_pass();
        wait_done(40000);
        check("a_done_once", n_done, 1);
        check("a_write_count", n_wr, 10080);
        check("a_first_addr", first_addr[0], 0);
        check("a_first_data", first_data, 5);
        check("a_last_addr", last_addr, 307199);
        check("a_left_edge", first_addr[9], 9);
        check("a_jump_to_right", first_addr[10], 629);
        check("a_row_end", first_addr[20], 639);
        check("a_next_row", first_addr[21], 640);

        // Transparent column 3.
        foreach (rom_tab[i]) rom_tab[i] = (i == 3) ? 4'd0 : 4'd7;
        start_pass();
        wait_done(40000);
        check("b_done_once", n_done, 1);
        check("b_write_count", n_wr, 9600);
        check("b_col3_writes", n_col3, 0);

        // Random sprite, first write held off for four cycles.
        foreach (rom_tab[i]) begin
            r = $urandom_range(0, 15);
            rom_tab[i] = (r < 4) ? 4'd0 : 4'(r);
        end
        rom_tab[0] = 4'd5;
        ack_man  = 1'b0;
        ack_mode = 2;
        start_pass();
        t = 0;
        do begin
            @(negedge Clk);
            t++;
        end while (!bus.fb_we && t < 20);
        for (int i = 0; i < 5; i++) begin
            check("hold_we", bus.fb_we, 1);
            check("hold_addr", bus.fb_addr, 0);
            check("hold_data", bus.fb_data, 5);
            if (i == 3) ack_man = 1'b1;
            if (i == 4) ack_man = 1'b0;
            @(negedge Clk);
        end
        check("we_drop_after_ack", bus.fb_we, 0);
        check("wr_count_after_hold", n_wr, 1);

        // Random acks (also landing in FETCH/NEXT) and start pulses while busy.
        ack_mode = 1;
        for (int k = 0; k < 3; k++) begin
            repeat (7) @(posedge Clk);
            #1 start = 1'b1;
            check("busy_during_start_pulse", busy, 1);
            @(posedge Clk);
            #1 start = 1'b0;
        end
        wait_write_at(2 * H_RES, a);
        check("d_write_count", n_wr, count_before(a) + (bus.fb_ack ? 1 : 0));
        Reset    = 1'b1;
        start    = 1'b1;
        checking = 1'b0;
        @(posedge Clk);
        #1 Reset = 1'b0;
        start = 1'b0;
        @(negedge Clk);
        check_reset_outputs("midwrite_reset");
        repeat (3) @(negedge Clk);
        check("start_with_reset_ignored", busy, 0);

        // Restart after reset.
        start_pass();
        wait_write_at(0, a);
        check("restart_first_addr", a, 0);
        wait_write_at(4 * H_RES, a);
        check("e_write_count", n_wr, count_before(a) + (bus.fb_ack ? 1 : 0));
        Reset    = 1'b1;
        checking = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wall_painter.md
WALL_PAINTER -- requirements
Module: wall_painter

Interface
REQ-001 Parameter H_RES, default 640, screen width in pixels.
REQ-002 Parameter V_RES, default 480, screen height in pixels.
REQ-003 Parameter LEFT_W, default 10, left wall spans columns 0..LEFT_W-1.
REQ-004 Parameter RIGHT_X, default 629, right wall spans columns RIGHT_X..H_RES-1.
REQ-005 Clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to paint both walls into the frame buffer.
REQ-008 rom_addr  output  19  read address to the wall sprite ROM, equal to the current column x.
REQ-009 rom_data  input  4  combinational palette index returned by the ROM for rom_addr.
REQ-010 fb_we  output  1  frame-buffer write request.
REQ-011 fb_addr  output  19  frame-buffer pixel address, y*H_RES+x.
REQ-012 fb_data  output  4  palette index to write.
REQ-013 fb_ack  input  1  frame buffer accepted the write this cycle.
REQ-014 busy  output  1  high from the cycle after an accepted start until DONE.
REQ-015 done  output  1  one-cycle pulse when the frame pass completes.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, WRITE, NEXT, DONE.
REQ-017 IDLE: start=1 -> FETCH with x=0, y=0, row_base=0; start ignored in all other states.
REQ-018 FETCH (1 cycle): rom_addr=x; rom_data registered into pix; go to WRITE if rom_data!=0, else NEXT (index 0 is transparent, never written).
REQ-019 WRITE: fb_we=1, fb_addr=row_base+x, fb_data=pix, all held stable until fb_ack=1; the ack cycle ends WRITE -> NEXT.
REQ-020 fb_ack outside WRITE SHALL be ignored.
REQ-021 NEXT (1 cycle): x advances 0..LEFT_W-1, then jumps from LEFT_W-1 to RIGHT_X, then RIGHT_X..H_RES-1; after x=H_RES-1, x=0, y+=1, row_base+=H_RES; -> FETCH.
REQ-022 After the pixel at x=H_RES-1, y=V_RES-1, NEXT SHALL go to DONE instead of FETCH.
REQ-023 DONE (1 cycle): done=1 -> IDLE; busy=0 in IDLE and DONE, 1 in FETCH/WRITE/NEXT.
REQ-024 row_base SHALL be computed incrementally (no multiplier); all address arithmetic 19-bit unsigned.
REQ-025 Per pixel: 2 cycles if transparent, 3+k cycles if written with fb_ack k cycles after WRITE entry.
REQ-026 Pixels per frame = V_RES*(LEFT_W+H_RES-RIGHT_X) = 10080 at defaults; fb_addr SHALL never exceed H_RES*V_RES-1.
REQ-027 fb_we SHALL be 0 in every state except WRITE.

Reset
REQ-028 Reset=1 at a rising edge SHALL force IDLE, x=0, y=0, row_base=0, pix=0, fb_we=0, fb_addr=0, fb_data=0, rom_addr=0, busy=0, done=0, regardless of state.
REQ-029 Reset mid-WRITE SHALL drop fb_we on that edge with no completion; start concurrent with Reset SHALL be ignored.

Verification
REQ-030 Reset then start with ROM all 5, fb_ack tied 1 -> first write fb_addr=0 data=5; 10080 writes, last fb_addr=307199; done pulses once.
REQ-031 ROM column 3 = 0, others 7 -> no write ever has fb_addr%640=3; 9600 writes total.
REQ-032 Row 0, x=9 written, then next write -> fb_addr 9 followed by 629; after x=639 next write fb_addr=640.
REQ-033 fb_ack held 0 for 4 cycles in first WRITE -> fb_we/fb_addr/fb_data stable 5 cycles, then advance.
REQ-034 Reset asserted during WRITE at y=2 -> next cycle fb_we=0, busy=0, state IDLE; new start restarts at fb_addr=0.
REQ-035 start pulsed while busy, and fb_ack pulsed in FETCH/NEXT -> no restart, no extra writes, write count unchanged.
